// File: rtl/mips_branch_pkg.sv
// Shared branch-unit definitions: opcode encoding, predictor counter reset
// value and the 2-bit saturating counter update.
package mips_branch_pkg;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BLEZ = 3'd2;
    localparam logic [2:0] BR_BGTZ = 3'd3;
    localparam logic [2:0] BR_BLTZ = 3'd4;
    localparam logic [2:0] BR_BGEZ = 3'd5;

    localparam logic [1:0] CTR_RESET = 2'b01;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of the MIPS conditional-branch set; zero-compares
// treat operand a as a signed WIDTH-bit value.
module branch_cond_eval
    import mips_branch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             taken,
    output logic             legal
);

    logic a_neg;
    logic a_zero;

    assign a_neg  = a[WIDTH-1];
    assign a_zero = (a == '0);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (op)
            BR_BEQ:  taken = (a == b);
            BR_BNE:  taken = (a != b);
            BR_BLEZ: taken = a_neg | a_zero;
            BR_BGTZ: taken = ~a_neg & ~a_zero;
            BR_BLTZ: taken = a_neg;
            BR_BGEZ: taken = ~a_neg;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_bht.sv
// EX-stage branch resolution with a 2-bit-counter branch history table,
// registered outcome/mispredict flags and saturating statistics.
module branch_resolve_bht
    import mips_branch_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 64,
    parameter int IDX_LSB   = 2,
    parameter int COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        if_pc,
    output logic               if_pred_taken,
    input  logic               ex_valid,
    input  logic [2:0]         ex_op,
    input  logic [31:0]        ex_pc,
    input  logic [WIDTH-1:0]   ex_a,
    input  logic [WIDTH-1:0]   ex_b,
    input  logic               ex_pred_taken,
    input  logic               stall,
    input  logic               flush,
    output logic               res_valid,
    output logic               res_taken,
    output logic               res_mispredict,
    output logic [COUNT_W-1:0] branch_cnt,
    output logic [COUNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]         bht_q [BHT_DEPTH];
    logic [IDX_W-1:0]   if_idx;
    logic [IDX_W-1:0]   ex_idx;
    logic               cond_taken;
    logic               cond_legal;
    logic               capture;
    logic               mispredict;
    logic               res_valid_q, res_taken_q, res_mispredict_q;
    logic               res_valid_d, res_taken_d, res_mispredict_d;
    logic [COUNT_W-1:0] branch_cnt_q, mispred_cnt_q;

    branch_cond_eval #(.WIDTH(WIDTH)) u_cond (
        .a     (ex_a),
        .b     (ex_b),
        .op    (ex_op),
        .taken (cond_taken),
        .legal (cond_legal)
    );

    assign if_idx        = if_pc[IDX_LSB +: IDX_W];
    assign ex_idx        = ex_pc[IDX_LSB +: IDX_W];
    assign if_pred_taken = bht_q[if_idx][1];

    assign capture    = ex_valid & cond_legal & ~stall & ~flush;
    assign mispredict = cond_taken ^ ex_pred_taken;

    // Lookup reads the flop array directly, so a same-cycle update is not bypassed.
    for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                bht_q[gi] <= CTR_RESET;
            end else if (capture && ex_idx == IDX_W'(gi)) begin
                bht_q[gi] <= ctr_update(bht_q[gi], cond_taken);
            end
        end
    end

    always_comb begin
        res_valid_d      = res_valid_q;
        res_taken_d      = res_taken_q;
        res_mispredict_d = res_mispredict_q;
        if (flush) begin
            res_valid_d      = 1'b0;
            res_taken_d      = 1'b0;
            res_mispredict_d = 1'b0;
        end else if (!stall) begin
            res_valid_d      = capture;
            res_taken_d      = capture & cond_taken;
            res_mispredict_d = capture & mispredict;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q      <= 1'b0;
            res_taken_q      <= 1'b0;
            res_mispredict_q <= 1'b0;
            branch_cnt_q     <= '0;
            mispred_cnt_q    <= '0;
        end else begin
            res_valid_q      <= res_valid_d;
            res_taken_q      <= res_taken_d;
            res_mispredict_q <= res_mispredict_d;
            if (capture && branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
            if (capture && mispredict && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + 1'b1;
        end
    end

    assign res_valid      = res_valid_q;
    assign res_taken      = res_taken_q;
    assign res_mispredict = res_mispredict_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc, ex_pc};

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht (COUNT_W=4 so statistic saturation is reachable).
module tb_branch_resolve_bht;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic [2:0]  ex_op;
    logic [31:0] ex_pc;
    logic [31:0] ex_a, ex_b;
    logic        ex_pred_taken;
    logic        stall, flush;
    logic        res_valid, res_taken, res_mispredict;
    logic [3:0]  branch_cnt, mispred_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_resolve_bht #(
        .WIDTH(32), .BHT_DEPTH(64), .IDX_LSB(2), .COUNT_W(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .ex_valid       (ex_valid),
        .ex_op          (ex_op),
        .ex_pc          (ex_pc),
        .ex_a           (ex_a),
        .ex_b           (ex_b),
        .ex_pred_taken  (ex_pred_taken),
        .stall          (stall),
        .flush          (flush),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .res_mispredict (res_mispredict),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b, input logic pred);
        ex_valid = v; ex_op = op; ex_pc = pc; ex_a = a; ex_b = b; ex_pred_taken = pred;
    endtask

    task automatic check_res(input string tag, input logic v, input logic t, input logic m,
                             input logic [3:0] bc, input logic [3:0] mc);
        check({tag, ".valid"}, {31'd0, res_valid}, {31'd0, v});
        check({tag, ".taken"}, {31'd0, res_taken}, {31'd0, t});
        check({tag, ".mis"},   {31'd0, res_mispredict}, {31'd0, m});
        check({tag, ".bcnt"},  {28'd0, branch_cnt}, {28'd0, bc});
        check({tag, ".mcnt"},  {28'd0, mispred_cnt}, {28'd0, mc});
    endtask

    localparam logic [31:0] PC_A = 32'h10;   // index 4
    localparam logic [31:0] PC_B = 32'h20;   // index 8
    localparam logic [31:0] PC_C = 32'h30;   // index 12
    localparam logic [31:0] PC_D = 32'h60;   // index 24

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; if_pc = PC_A;
        drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        step(); step();
        check_res("reset", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        check("reset.pred", {31'd0, if_pred_taken}, 32'd0);
        rst_n = 1'b1;
        step();

        // Each op once, against hand-computed direction and mispredict.
        drive(1'b1, 3'd0, 32'h40, 32'd5, 32'd5, 1'b0); step();
        check_res("beq_eq", 1'b1, 1'b1, 1'b1, 4'd1, 4'd1);
        drive(1'b1, 3'd2, 32'h44, 32'hFFFF_FFFF, 32'd7, 1'b1); step();
        check_res("blez_m1", 1'b1, 1'b1, 1'b0, 4'd2, 4'd1);
        drive(1'b1, 3'd3, 32'h48, 32'h8000_0000, 32'd0, 1'b0); step();
        check_res("bgtz_min", 1'b1, 1'b0, 1'b0, 4'd3, 4'd1);
        drive(1'b1, 3'd5, 32'h4C, 32'h0, 32'd9, 1'b1); step();
        check_res("bgez_0", 1'b1, 1'b1, 1'b0, 4'd4, 4'd1);
        drive(1'b1, 3'd4, 32'h50, 32'h1, 32'd0, 1'b0); step();
        check_res("bltz_1", 1'b1, 1'b0, 1'b0, 4'd5, 4'd1);

        // Counter training on PC_A: 01 -> 10 -> 11 -> 11 -> 10 -> 01.
        if_pc = PC_A;
        drive(1'b1, 3'd1, PC_A, 32'd1, 32'd2, 1'b0); #1;
        check("train.pre", {31'd0, if_pred_taken}, 32'd0);
        step(); check("train.t1", {31'd0, if_pred_taken}, 32'd1);
        step(); check("train.t2", {31'd0, if_pred_taken}, 32'd1);
        step(); check("train.t3", {31'd0, if_pred_taken}, 32'd1);
        check_res("train.t3", 1'b1, 1'b1, 1'b1, 4'd8, 4'd4);
        drive(1'b1, 3'd0, PC_A, 32'd1, 32'd2, 1'b1);
        step(); check("train.n1", {31'd0, if_pred_taken}, 32'd1);
        #1; check("same_cycle_old", {31'd0, if_pred_taken}, 32'd1);
        step(); check("train.n2", {31'd0, if_pred_taken}, 32'd0);
        check_res("train.n2", 1'b1, 1'b0, 1'b1, 4'd10, 4'd6);

        drive(1'b0, 3'd0, 32'h0, 32'd0, 32'd0, 1'b0); step();
        check_res("idle", 1'b0, 1'b0, 1'b0, 4'd10, 4'd6);

        // Stall holds a valid result and blocks training.
        if_pc = PC_B;
        drive(1'b1, 3'd0, PC_B, 32'd3, 32'd3, 1'b1); step();
        check_res("pre_stall", 1'b1, 1'b1, 1'b0, 4'd11, 4'd6);
        drive(1'b1, 3'd0, PC_B, 32'd3, 32'd3, 1'b0); stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_res($sformatf("stall%0d", i), 1'b1, 1'b1, 1'b0, 4'd11, 4'd6);
        end
        stall = 1'b0; step();
        check_res("stall_rel", 1'b1, 1'b1, 1'b1, 4'd12, 4'd7);
        drive(1'b0, 3'd0, 32'h0, 32'd0, 32'd0, 1'b0); step();
        check_res("stall_once", 1'b0, 1'b0, 1'b0, 4'd12, 4'd7);

        // Flush beats stall and ex_valid; PC_C stays at 01 if untrained.
        if_pc = PC_C;
        drive(1'b1, 3'd0, PC_C, 32'd4, 32'd4, 1'b0); stall = 1'b1; flush = 1'b1; step();
        stall = 1'b0; flush = 1'b0;
        check_res("flush", 1'b0, 1'b0, 1'b0, 4'd12, 4'd7);
        check("flush.pred", {31'd0, if_pred_taken}, 32'd0);

        drive(1'b1, 3'd7, PC_C, 32'd4, 32'd4, 1'b0); step();
        check_res("illegal", 1'b0, 1'b0, 1'b0, 4'd12, 4'd7);
        check("illegal.pred", {31'd0, if_pred_taken}, 32'd0);

        // 20 mispredicted branches: both statistics stick at all-ones.
        if_pc = PC_D;
        drive(1'b1, 3'd0, PC_D, 32'd8, 32'd8, 1'b0);
        for (int i = 0; i < 20; i++) step();
        check_res("sat", 1'b1, 1'b1, 1'b1, 4'd15, 4'd15);
        check("sat.pred", {31'd0, if_pred_taken}, 32'd1);

        // Asynchronous reset between edges.
        drive(1'b0, 3'd0, 32'h0, 32'd0, 32'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_res("async_rst", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        check("async_rst.pred", {31'd0, if_pred_taken}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
